// File: rtl/pf_clk_div_pkg.sv
// Shared definitions for the soft clock-divider / delay-tap cell.
//   DIV_MIN    : smallest ratio the divider will accept on a load
//   ceil_half  : high-time of the divided square wave for a given ratio
//   DIR_UP/DN  : tap step direction encoding on DELAY_LINE_DIR
//   tap_req_t  : per-cycle request bundle into the tap controller
package pf_clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef struct packed {
    logic load;
    logic move;
    logic dir;
  } tap_req_t;

  // Odd ratios get the extra cycle in the high half (N=5 -> 3 high, 2 low).
  function automatic int unsigned ceil_half(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/pf_delay_tap_ctrl.sv
// Saturating delay-tap register with sticky out-of-range flag.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : load / move / dir request for this cycle (load wins)
//   val_in     : value taken on load
//   val        : current tap (registered, 1-cycle latency)
//   oor        : set when a move hits a limit, cleared by any load or good move
module pf_delay_tap_ctrl
  import pf_clk_div_pkg::*;
#(
  parameter int unsigned DELAY_WIDTH   = 8,
  parameter int unsigned DELAY_DEFAULT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  tap_req_t               req,
  input  logic [DELAY_WIDTH-1:0] val_in,
  output logic [DELAY_WIDTH-1:0] val,
  output logic                   oor
);

  localparam logic [DELAY_WIDTH-1:0] TAP_RST = DELAY_WIDTH'(DELAY_DEFAULT);
  localparam logic [DELAY_WIDTH-1:0] TAP_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val <= TAP_RST;
      oor <= 1'b0;
    end else if (req.load) begin
      val <= val_in;
      oor <= 1'b0;
    end else if (req.move) begin
      if (req.dir == DIR_UP) begin
        if (val == TAP_MAX) oor <= 1'b1;
        else begin
          val <= val + 1'b1;
          oor <= 1'b0;
        end
      end else if (req.dir == DIR_DN) begin
        if (val == '0) oor <= 1'b1;
        else begin
          val <= val - 1'b1;
          oor <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pf_clk_div_delay_ctrl.sv
// Parametrised clock divider with bit-slip and delay-tap control.
//   CLK_IN, RST_N         : clock, synchronous active-low reset
//   DIV_LOAD/DIV_VAL      : ratio reload request (applied at next wrap)
//   BIT_SLIP              : hold the phase counter one cycle
//   DELAY_LINE_*          : tap load / step controls and tap value
//   DIV_STROBE            : pulse when DIV_PHASE==0
//   DIV_CLK_OUT           : divided square wave, high for ceil(N/2) phases
//   DIV_PHASE/DIV_RATIO   : current phase and active ratio
//   DIV_ERR               : pulse on a rejected ratio load
//   SLIP_BUSY             : slip taken, waiting for the next strobe
//   DELAY_LINE_OUT_OF_RANGE : last move tried to pass a limit
// All outputs are registered.
module pf_clk_div_delay_ctrl
  import pf_clk_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH     = 4,
  parameter int unsigned DIV_DEFAULT   = 5,
  parameter int unsigned DELAY_WIDTH   = 8,
  parameter int unsigned DELAY_DEFAULT = 0
) (
  input  logic                   CLK_IN,
  input  logic                   RST_N,
  input  logic                   DIV_LOAD,
  input  logic [DIV_WIDTH-1:0]   DIV_VAL,
  input  logic                   BIT_SLIP,
  input  logic                   DELAY_LINE_LOAD,
  input  logic                   DELAY_LINE_MOVE,
  input  logic                   DELAY_LINE_DIR,
  input  logic [DELAY_WIDTH-1:0] DELAY_LINE_VAL_IN,
  output logic                   DIV_STROBE,
  output logic                   DIV_CLK_OUT,
  output logic [DIV_WIDTH-1:0]   DIV_PHASE,
  output logic [DIV_WIDTH-1:0]   DIV_RATIO,
  output logic                   DIV_ERR,
  output logic                   SLIP_BUSY,
  output logic [DELAY_WIDTH-1:0] DELAY_LINE_VAL,
  output logic                   DELAY_LINE_OUT_OF_RANGE
);

  localparam logic [DIV_WIDTH-1:0] RATIO_RST = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0] RATIO_MIN = DIV_WIDTH'(DIV_MIN);

  logic                 pend_vld;
  logic [DIV_WIDTH-1:0] pend_val;

  logic                 slip_acc, wrap, pend_clr, load_ok;
  logic                 strobe_nxt, clk_nxt, busy_nxt;
  logic [DIV_WIDTH-1:0] phase_nxt, ratio_nxt;

  always_comb begin
    slip_acc  = BIT_SLIP & ~SLIP_BUSY;
    wrap      = (DIV_PHASE == DIV_RATIO - 1'b1);
    phase_nxt = DIV_PHASE;
    ratio_nxt = DIV_RATIO;
    pend_clr  = 1'b0;
    // A slip freezes the counter; a wrap landing on that cycle, and any
    // ratio swap riding on it, simply slide one cycle later.
    if (!slip_acc) begin
      if (wrap) begin
        phase_nxt = '0;
        if (pend_vld) begin
          ratio_nxt = pend_val;
          pend_clr  = 1'b1;
        end
      end else begin
        phase_nxt = DIV_PHASE + 1'b1;
      end
    end
    load_ok    = DIV_LOAD & (DIV_VAL >= RATIO_MIN);
    strobe_nxt = (phase_nxt == '0);
    clk_nxt    = (32'(phase_nxt) < ceil_half(32'(ratio_nxt)));
    busy_nxt   = slip_acc | (SLIP_BUSY & ~strobe_nxt);
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      DIV_PHASE   <= '0;
      DIV_RATIO   <= RATIO_RST;
      DIV_STROBE  <= 1'b0;
      DIV_CLK_OUT <= 1'b0;
      DIV_ERR     <= 1'b0;
      SLIP_BUSY   <= 1'b0;
      pend_vld    <= 1'b0;
      pend_val    <= '0;
    end else begin
      DIV_PHASE   <= phase_nxt;
      DIV_RATIO   <= ratio_nxt;
      DIV_STROBE  <= strobe_nxt;
      DIV_CLK_OUT <= clk_nxt;
      DIV_ERR     <= DIV_LOAD & ~load_ok;
      SLIP_BUSY   <= busy_nxt;
      // A load arriving on the swap cycle becomes the next pending value.
      if (load_ok) begin
        pend_vld <= 1'b1;
        pend_val <= DIV_VAL;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
    end
  end

  tap_req_t tap_req;
  assign tap_req = '{load: DELAY_LINE_LOAD, move: DELAY_LINE_MOVE, dir: DELAY_LINE_DIR};

  pf_delay_tap_ctrl #(
    .DELAY_WIDTH   (DELAY_WIDTH),
    .DELAY_DEFAULT (DELAY_DEFAULT)
  ) u_tap (
    .clk    (CLK_IN),
    .rst_n  (RST_N),
    .req    (tap_req),
    .val_in (DELAY_LINE_VAL_IN),
    .val    (DELAY_LINE_VAL),
    .oor    (DELAY_LINE_OUT_OF_RANGE)
  );

endmodule

// File: tb/tb_pf_clk_div_delay_ctrl.sv
module tb_pf_clk_div_delay_ctrl;

  logic       CLK_IN = 1'b0;
  logic       RST_N;
  logic       DIV_LOAD;
  logic [3:0] DIV_VAL;
  logic       BIT_SLIP;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIR;
  logic [7:0] DELAY_LINE_VAL_IN;
  logic       DIV_STROBE, DIV_CLK_OUT, DIV_ERR, SLIP_BUSY;
  logic [3:0] DIV_PHASE, DIV_RATIO;
  logic [7:0] DELAY_LINE_VAL;
  logic       DELAY_LINE_OUT_OF_RANGE;

  int checks = 0;
  int errors = 0;

  always #5 CLK_IN = ~CLK_IN;

  pf_clk_div_delay_ctrl dut (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .DIV_LOAD(DIV_LOAD), .DIV_VAL(DIV_VAL),
    .BIT_SLIP(BIT_SLIP), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIR(DELAY_LINE_DIR),
    .DELAY_LINE_VAL_IN(DELAY_LINE_VAL_IN), .DIV_STROBE(DIV_STROBE),
    .DIV_CLK_OUT(DIV_CLK_OUT), .DIV_PHASE(DIV_PHASE), .DIV_RATIO(DIV_RATIO),
    .DIV_ERR(DIV_ERR), .SLIP_BUSY(SLIP_BUSY), .DELAY_LINE_VAL(DELAY_LINE_VAL),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
  );

  // Reference model: time position inside the divided period, the ratio in
  // force, an optional queued ratio (0 = none) and the slip-wait flag.
  int m_pos, m_n, m_queued, m_tap;
  bit m_wait, m_strobe, m_clk, m_err, m_oor;

  task automatic model_step();
    bit took;
    if (!RST_N) begin
      m_pos = 0; m_n = 5; m_queued = 0; m_wait = 0;
      m_strobe = 0; m_clk = 0; m_err = 0; m_tap = 0; m_oor = 0;
      return;
    end
    took = BIT_SLIP && !m_wait;
    if (!took) begin
      m_pos = m_pos + 1;
      if (m_pos >= m_n) begin
        m_pos = 0;
        if (m_queued != 0) begin m_n = m_queued; m_queued = 0; end
      end
    end
    m_err = DIV_LOAD && (int'(DIV_VAL) < 2);
    if (DIV_LOAD && int'(DIV_VAL) >= 2) m_queued = int'(DIV_VAL);
    m_strobe = (m_pos == 0);
    m_clk    = (2 * m_pos < m_n);
    if (took) m_wait = 1;
    else if (m_strobe) m_wait = 0;
    if (DELAY_LINE_LOAD) begin
      m_tap = int'(DELAY_LINE_VAL_IN); m_oor = 0;
    end else if (DELAY_LINE_MOVE) begin
      if ((DELAY_LINE_DIR && m_tap == 255) || (!DELAY_LINE_DIR && m_tap == 0)) m_oor = 1;
      else begin m_tap = DELAY_LINE_DIR ? m_tap + 1 : m_tap - 1; m_oor = 0; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic idle();
    DIV_LOAD = 0; DIV_VAL = 0; BIT_SLIP = 0;
    DELAY_LINE_LOAD = 0; DELAY_LINE_MOVE = 0; DELAY_LINE_DIR = 0; DELAY_LINE_VAL_IN = 0;
  endtask

  // Advances until DIV_STROBE; n = cycles taken, or -1 if none within budget.
  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (DIV_STROBE) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    RST_N = 0; idle();
    tick(); tick();
    checks++; if (DIV_PHASE !== 4'd0) begin errors++; $display("FAIL rst_phase got %0d exp 0", DIV_PHASE); end
    checks++; if (DIV_STROBE !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b exp 0", DIV_STROBE); end
    checks++; if (DIV_CLK_OUT !== 1'b0) begin errors++; $display("FAIL rst_clk got %b exp 0", DIV_CLK_OUT); end
    checks++; if (DIV_RATIO !== 4'd5) begin errors++; $display("FAIL rst_ratio got %0d exp 5", DIV_RATIO); end
    checks++; if (DIV_ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", DIV_ERR); end
    checks++; if (SLIP_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", SLIP_BUSY); end
    checks++; if (DELAY_LINE_VAL !== 8'd0) begin errors++; $display("FAIL rst_tap got %0d exp 0", DELAY_LINE_VAL); end
    checks++; if (DELAY_LINE_OUT_OF_RANGE !== 1'b0) begin errors++; $display("FAIL rst_oor got %b exp 0", DELAY_LINE_OUT_OF_RANGE); end
  endtask

  task automatic test_default_run();
    RST_N = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (DIV_PHASE !== 4'(i % 5)) begin errors++; $display("FAIL run_phase cyc %0d got %0d exp %0d", i, DIV_PHASE, i % 5); end
      checks++; if (DIV_STROBE !== (i % 5 == 0)) begin errors++; $display("FAIL run_strobe cyc %0d got %b", i, DIV_STROBE); end
      checks++; if (DIV_CLK_OUT !== (i % 5 < 3)) begin errors++; $display("FAIL run_clk cyc %0d got %b", i, DIV_CLK_OUT); end
    end
    checks++; if (DIV_RATIO !== 4'd5) begin errors++; $display("FAIL run_ratio got %0d exp 5", DIV_RATIO); end
  endtask

  task automatic test_ratio_load();
    int n, hi;
    checks++; if (DIV_PHASE !== 4'd2) begin errors++; $display("FAIL load_start_phase got %0d exp 2", DIV_PHASE); end
    DIV_LOAD = 1; DIV_VAL = 4'd8; tick(); idle();
    checks++; if (DIV_RATIO !== 4'd5) begin errors++; $display("FAIL load_early_ratio got %0d exp 5", DIV_RATIO); end
    wait_strobe(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL load_first_wrap got %0d exp 2", n); end
    checks++; if (DIV_RATIO !== 4'd8) begin errors++; $display("FAIL load_ratio got %0d exp 8", DIV_RATIO); end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      for (int i = 1; i <= 8; i++) begin tick(); if (DIV_CLK_OUT) hi++; end
      checks++; if (DIV_STROBE !== 1'b1) begin errors++; $display("FAIL load_period8 got strobe %b exp 1", DIV_STROBE); end
      checks++; if (hi !== 4) begin errors++; $display("FAIL load_high8 got %0d exp 4", hi); end
    end
  endtask

  task automatic test_bad_load();
    int n;
    for (int v = 0; v < 2; v++) begin
      DIV_LOAD = 1; DIV_VAL = 4'(v); tick(); idle();
      checks++; if (DIV_ERR !== 1'b1) begin errors++; $display("FAIL bad_err_val%0d got %b exp 1", v, DIV_ERR); end
      tick();
      checks++; if (DIV_ERR !== 1'b0) begin errors++; $display("FAIL bad_err_pulse got %b exp 0", DIV_ERR); end
    end
    wait_strobe(n);
    wait_strobe(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL bad_period got %0d exp 8", n); end
    checks++; if (DIV_RATIO !== 4'd8) begin errors++; $display("FAIL bad_ratio got %0d exp 8", DIV_RATIO); end
  endtask

  task automatic test_slip();
    int n;
    DIV_LOAD = 1; DIV_VAL = 4'd5; tick(); idle();
    wait_strobe(n);
    checks++; if (DIV_RATIO !== 4'd5) begin errors++; $display("FAIL slip_ratio5 got %0d exp 5", DIV_RATIO); end
    tick(); tick(); tick();
    checks++; if (DIV_PHASE !== 4'd3) begin errors++; $display("FAIL slip_pre_phase got %0d exp 3", DIV_PHASE); end
    BIT_SLIP = 1; tick();
    checks++; if (DIV_PHASE !== 4'd3) begin errors++; $display("FAIL slip_hold got %0d exp 3", DIV_PHASE); end
    checks++; if (SLIP_BUSY !== 1'b1) begin errors++; $display("FAIL slip_busy_rise got %b exp 1", SLIP_BUSY); end
    tick(); idle();  // second slip while busy must be ignored
    checks++; if (DIV_PHASE !== 4'd4) begin errors++; $display("FAIL slip_ignored got %0d exp 4", DIV_PHASE); end
    checks++; if (SLIP_BUSY !== 1'b1) begin errors++; $display("FAIL slip_busy_hold got %b exp 1", SLIP_BUSY); end
    wait_strobe(n);
    checks++; if (n + 5 !== 6) begin errors++; $display("FAIL slip_interval got %0d exp 6", n + 5); end
    checks++; if (SLIP_BUSY !== 1'b0) begin errors++; $display("FAIL slip_busy_clear got %b exp 0", SLIP_BUSY); end
    wait_strobe(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL slip_after got %0d exp 5", n); end
  endtask

  task automatic test_slip_wrap();
    int n;
    DIV_LOAD = 1; DIV_VAL = 4'd3; tick(); idle();
    tick(); tick(); tick();
    checks++; if (DIV_PHASE !== 4'd4) begin errors++; $display("FAIL sw_phase got %0d exp 4", DIV_PHASE); end
    BIT_SLIP = 1; tick(); idle();
    checks++; if (DIV_PHASE !== 4'd4 || DIV_RATIO !== 4'd5) begin errors++; $display("FAIL sw_hold got phase %0d ratio %0d exp 4 5", DIV_PHASE, DIV_RATIO); end
    wait_strobe(n);
    checks++; if (n + 5 !== 6) begin errors++; $display("FAIL sw_interval got %0d exp 6", n + 5); end
    checks++; if (DIV_RATIO !== 4'd3) begin errors++; $display("FAIL sw_ratio got %0d exp 3", DIV_RATIO); end
    wait_strobe(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL sw_period3 got %0d exp 3", n); end
  endtask

  task automatic test_tap();
    DELAY_LINE_LOAD = 1; DELAY_LINE_VAL_IN = 8'd254; tick(); idle();
    checks++; if (DELAY_LINE_VAL !== 8'd254) begin errors++; $display("FAIL tap_load got %0d exp 254", DELAY_LINE_VAL); end
    DELAY_LINE_MOVE = 1; DELAY_LINE_DIR = 1; tick();
    checks++; if (DELAY_LINE_VAL !== 8'd255 || DELAY_LINE_OUT_OF_RANGE !== 1'b0) begin errors++; $display("FAIL tap_up got %0d/%b exp 255/0", DELAY_LINE_VAL, DELAY_LINE_OUT_OF_RANGE); end
    tick();
    checks++; if (DELAY_LINE_VAL !== 8'd255 || DELAY_LINE_OUT_OF_RANGE !== 1'b1) begin errors++; $display("FAIL tap_sat_hi got %0d/%b exp 255/1", DELAY_LINE_VAL, DELAY_LINE_OUT_OF_RANGE); end
    DELAY_LINE_DIR = 0; tick();
    checks++; if (DELAY_LINE_VAL !== 8'd254 || DELAY_LINE_OUT_OF_RANGE !== 1'b0) begin errors++; $display("FAIL tap_dn got %0d/%b exp 254/0", DELAY_LINE_VAL, DELAY_LINE_OUT_OF_RANGE); end
    DELAY_LINE_LOAD = 1; DELAY_LINE_VAL_IN = 8'd0; tick(); DELAY_LINE_LOAD = 0;
    checks++; if (DELAY_LINE_VAL !== 8'd0 || DELAY_LINE_OUT_OF_RANGE !== 1'b0) begin errors++; $display("FAIL tap_load_prio got %0d/%b exp 0/0", DELAY_LINE_VAL, DELAY_LINE_OUT_OF_RANGE); end
    tick(); idle();
    checks++; if (DELAY_LINE_VAL !== 8'd0 || DELAY_LINE_OUT_OF_RANGE !== 1'b1) begin errors++; $display("FAIL tap_sat_lo got %0d/%b exp 0/1", DELAY_LINE_VAL, DELAY_LINE_OUT_OF_RANGE); end
    tick();
    checks++; if (DELAY_LINE_OUT_OF_RANGE !== 1'b1) begin errors++; $display("FAIL tap_sticky got %b exp 1", DELAY_LINE_OUT_OF_RANGE); end
  endtask

  task automatic test_reset_mid();
    int n;
    wait_strobe(n);
    DIV_LOAD = 1; DIV_VAL = 4'd9; tick(); idle();
    BIT_SLIP = 1; tick(); idle();
    checks++; if (SLIP_BUSY !== 1'b1) begin errors++; $display("FAIL rm_busy got %b exp 1", SLIP_BUSY); end
    RST_N = 0; tick();
    checks++; if (DIV_PHASE !== 4'd0 || DIV_STROBE !== 1'b0 || DIV_CLK_OUT !== 1'b0) begin errors++; $display("FAIL rm_div got %0d/%b/%b exp 0/0/0", DIV_PHASE, DIV_STROBE, DIV_CLK_OUT); end
    checks++; if (DIV_RATIO !== 4'd5 || SLIP_BUSY !== 1'b0 || DIV_ERR !== 1'b0) begin errors++; $display("FAIL rm_ctl got %0d/%b/%b exp 5/0/0", DIV_RATIO, SLIP_BUSY, DIV_ERR); end
    checks++; if (DELAY_LINE_VAL !== 8'd0 || DELAY_LINE_OUT_OF_RANGE !== 1'b0) begin errors++; $display("FAIL rm_tap got %0d/%b exp 0/0", DELAY_LINE_VAL, DELAY_LINE_OUT_OF_RANGE); end
    RST_N = 1;
    wait_strobe(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rm_first got %0d exp 5", n); end
    wait_strobe(n);
    checks++; if (n !== 5 || DIV_RATIO !== 4'd5) begin errors++; $display("FAIL rm_discard got %0d ratio %0d exp 5 5", n, DIV_RATIO); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RST_N             = ($urandom_range(0, 149) != 0);
      DIV_LOAD          = ($urandom_range(0, 7) == 0);
      DIV_VAL           = 4'($urandom_range(0, 15));
      BIT_SLIP          = ($urandom_range(0, 9) == 0);
      DELAY_LINE_LOAD   = ($urandom_range(0, 9) == 0);
      DELAY_LINE_MOVE   = ($urandom_range(0, 1) == 0);
      DELAY_LINE_DIR    = 1'($urandom_range(0, 1));
      DELAY_LINE_VAL_IN = ($urandom_range(0, 3) == 0) ? 8'(254 + $urandom_range(0, 1)) : 8'($urandom_range(0, 255));
      tick();
      checks++;
      if (DIV_PHASE !== 4'(m_pos) || DIV_RATIO !== 4'(m_n) || DIV_STROBE !== m_strobe ||
          DIV_CLK_OUT !== m_clk || DIV_ERR !== m_err || SLIP_BUSY !== m_wait ||
          DELAY_LINE_VAL !== 8'(m_tap) || DELAY_LINE_OUT_OF_RANGE !== m_oor) begin
        errors++;
        $display("FAIL rand cyc %0d got ph%0d n%0d s%b c%b e%b b%b t%0d o%b exp ph%0d n%0d s%b c%b e%b b%b t%0d o%b",
                 i, DIV_PHASE, DIV_RATIO, DIV_STROBE, DIV_CLK_OUT, DIV_ERR, SLIP_BUSY, DELAY_LINE_VAL,
                 DELAY_LINE_OUT_OF_RANGE, m_pos, m_n, m_strobe, m_clk, m_err, m_wait, m_tap, m_oor);
      end
    end
    idle(); RST_N = 1;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_ratio_load();
    test_bad_load();
    test_slip();
    test_slip_wrap();
    test_tap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
